// File: rtl/simon_timer_pkg.sv
// Shared types and constants for the Simon pacing timer (prog_timer).
package simon_timer_pkg;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } timer_state_e;

  localparam logic TMODE_ONESHOT  = 1'b0;
  localparam logic TMODE_PERIODIC = 1'b1;

  localparam int TIMER_WIDTH_DEF      = 26;
  localparam int TIMER_EXP_W_DEF      = 8;
  localparam int TIMER_PRESCALE_W_DEF = 8;

endpackage : simon_timer_pkg

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles by (prescale+1); used by prog_timer when
// PROG_TIMER_PRESCALE_EN is defined.
module tick_prescaler #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] prescale_i,
  input  logic         enable_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] presc_q;
  logic         wrap_s;

  assign wrap_s = (cnt_q == presc_q);
  assign tick_o = enable_i & wrap_s;

  // Divider counter; clearing restarts the (prescale+1) window from zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= {W{1'b0}};
      presc_q <= {W{1'b0}};
    end else begin
      if (load_i) begin
        presc_q <= prescale_i;
      end else begin
        presc_q <= presc_q;
      end
      if (clear_i) begin
        cnt_q <= {W{1'b0}};
      end else if (enable_i) begin
        cnt_q <= wrap_s ? {W{1'b0}} : cnt_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

endmodule : tick_prescaler

// File: rtl/prog_timer.sv
// Programmable countdown timer with one-shot/periodic modes and expiry pulse.
// Optional tick prescaler enabled by defining PROG_TIMER_PRESCALE_EN.
module prog_timer
  import simon_timer_pkg::*;
#(
  parameter int WIDTH      = TIMER_WIDTH_DEF,
`ifdef PROG_TIMER_PRESCALE_EN
  parameter int PRESCALE_W = TIMER_PRESCALE_W_DEF,
`endif
  parameter int EXP_W      = TIMER_EXP_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      loadvalue,
`ifdef PROG_TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic                  pulse,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      count,
  output logic [EXP_W-1:0]      exp_count
);

  timer_state_e     state_q;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic [WIDTH-1:0] count_q;
  logic [EXP_W-1:0] exp_count_q;
  logic             pulse_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] period_d;
  logic [EXP_W-1:0] exp_count_d;
  logic             tick_s;
  logic             expire_s;

`ifdef PROG_TIMER_PRESCALE_EN
  tick_prescaler #(
    .W(PRESCALE_W)
  ) u_prescaler (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (start | stop),
    .load_i    (start & ~stop),
    .prescale_i(prescale),
    .enable_i  (enable),
    .tick_o    (tick_s)
  );
`else
  assign tick_s = enable;
`endif

  // A zero period would never expire, so it is promoted to one tick.
  assign period_d    = (loadvalue == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : loadvalue;
  assign exp_count_d = (&exp_count_q) ? exp_count_q : exp_count_q + {{(EXP_W-1){1'b0}}, 1'b1};
  assign expire_s    = tick_s && (count_q <= {{(WIDTH-1){1'b0}}, 1'b1});

  // Timer FSM: stop beats start, start beats expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= T_IDLE;
      period_q    <= {WIDTH{1'b0}};
      mode_q      <= TMODE_ONESHOT;
      count_q     <= {WIDTH{1'b0}};
      exp_count_q <= {EXP_W{1'b0}};
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (stop) begin
        state_q <= T_IDLE;
        count_q <= {WIDTH{1'b0}};
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (start) begin
        state_q     <= T_RUN;
        period_q    <= period_d;
        mode_q      <= mode;
        count_q     <= period_d;
        exp_count_q <= {EXP_W{1'b0}};
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
      end else begin
        case (state_q)
          T_RUN: begin
            if (expire_s) begin
              pulse_q     <= 1'b1;
              exp_count_q <= exp_count_d;
              if (mode_q == TMODE_PERIODIC) begin
                count_q <= period_q;
              end else begin
                count_q <= {WIDTH{1'b0}};
                state_q <= T_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else if (tick_s) begin
              count_q <= count_q - {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
              count_q <= count_q;
            end
          end
          T_IDLE: begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
          T_DONE: begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: begin
            state_q <= T_IDLE;
            count_q <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;
  assign exp_count = exp_count_q;

endmodule : prog_timer

// File: tb/tb_prog_timer.sv
// Directed, table-driven bench for prog_timer.
module tb_prog_timer;

  localparam int WIDTH = 26;
  localparam int EXP_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] loadvalue;
`ifdef PROG_TIMER_PRESCALE_EN
  logic [7:0]       prescale;
`endif
  logic             pulse;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  logic [EXP_W-1:0] exp_count;

  int checks = 0;
  int errors = 0;

  prog_timer dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .loadvalue(loadvalue),
`ifdef PROG_TIMER_PRESCALE_EN
    .prescale (prescale),
`endif
    .pulse    (pulse),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .exp_count(exp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        md;
    logic        en;
    logic [31:0] lv;
    logic        e_pulse;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_count;
    logic [31:0] e_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic st, input logic sp, input logic md, input logic en,
                      input int lv, input logic p, input logic b, input logic d,
                      input int c, input int e);
    vec_t v;
    v.st = st; v.sp = sp; v.md = md; v.en = en; v.lv = lv;
    v.e_pulse = p; v.e_busy = b; v.e_done = d; v.e_count = c; v.e_exp = e;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    loadvalue = '0;
`ifdef PROG_TIMER_PRESCALE_EN
    prescale = 8'd0;
`endif
    #12;
    check("reset_pulse", {31'd0, pulse}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_exp", 32'(exp_count), 32'd0);
    reset = 1'b0;
    step();

    //     st sp md en lv   pulse busy done count exp
    addv(1, 0, 0, 1, 3,   0, 1, 0, 3, 0);   // one-shot L=3
    addv(0, 0, 0, 1, 0,   0, 1, 0, 2, 0);
    addv(0, 0, 0, 1, 0,   0, 1, 0, 1, 0);
    addv(0, 0, 0, 1, 0,   1, 0, 1, 0, 1);   // expiry at start+3
    addv(0, 0, 0, 1, 0,   0, 0, 1, 0, 1);
    addv(1, 0, 1, 1, 2,   0, 1, 0, 2, 0);   // periodic L=2
    addv(0, 0, 0, 1, 0,   0, 1, 0, 1, 0);
    addv(0, 0, 0, 1, 0,   1, 1, 0, 2, 1);
    addv(0, 0, 0, 0, 0,   0, 1, 0, 2, 1);   // paused
    addv(0, 0, 0, 0, 0,   0, 1, 0, 2, 1);
    addv(0, 0, 0, 1, 0,   0, 1, 0, 1, 1);
    addv(0, 0, 0, 1, 0,   1, 1, 0, 2, 2);
    addv(0, 0, 0, 1, 0,   0, 1, 0, 1, 2);
    addv(0, 1, 0, 1, 0,   0, 0, 0, 0, 2);   // stop on expiry cycle
    addv(1, 1, 1, 1, 9,   0, 0, 0, 0, 2);   // start+stop: stop wins
    addv(1, 0, 0, 1, 0,   0, 1, 0, 1, 0);   // loadvalue 0 -> L=1
    addv(0, 0, 0, 1, 0,   1, 0, 1, 0, 1);
    addv(0, 0, 0, 1, 0,   0, 0, 1, 0, 1);
    addv(1, 0, 1, 1, 3,   0, 1, 0, 3, 0);   // periodic L=3
    addv(0, 0, 0, 1, 0,   0, 1, 0, 2, 0);
    addv(0, 0, 0, 1, 0,   0, 1, 0, 1, 0);
    addv(1, 0, 1, 1, 7,   0, 1, 0, 7, 0);   // restart at expiry
    for (int k = 6; k >= 1; k--) addv(0, 0, 0, 1, 100 + k, 0, 1, 0, k, 0);
    addv(0, 0, 0, 1, 55,  1, 1, 0, 7, 1);   // reload keeps latched 7
    addv(0, 0, 0, 1, 0,   0, 1, 0, 6, 1);

    foreach (vecs[i]) begin
      start = vecs[i].st; stop = vecs[i].sp; mode = vecs[i].md;
      enable = vecs[i].en; loadvalue = vecs[i].lv[WIDTH-1:0];
      step();
      check($sformatf("v%0d_pulse", i), {31'd0, pulse}, {31'd0, vecs[i].e_pulse});
      check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].e_done});
      check($sformatf("v%0d_count", i), 32'(count), vecs[i].e_count);
      check($sformatf("v%0d_exp", i), 32'(exp_count), vecs[i].e_exp);
    end

    // One-shot L=5 then quiet: done holds, no more pulses.
    start = 1'b1; stop = 1'b0; mode = 1'b0; enable = 1'b1; loadvalue = 26'd5;
    step();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      check($sformatf("os_pulse_c%0d", k), {31'd0, pulse}, (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("os_done_c%0d", k), {31'd0, done}, (k >= 5) ? 32'd1 : 32'd0);
    end
    check("os_exp", 32'(exp_count), 32'd1);

    // Periodic L=1 saturates exp_count with a continuous pulse.
    start = 1'b1; mode = 1'b1; loadvalue = 26'd1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (pulse !== 1'b1) check($sformatf("l1_pulse_c%0d", k), {31'd0, pulse}, 32'd1);
      if (k == 100) check("l1_exp_100", 32'(exp_count), 32'd100);
    end
    check("l1_exp_sat", 32'(exp_count), 32'd255);
    check("l1_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    check("areset_pulse", {31'd0, pulse}, 32'd0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_count", 32'(count), 32'd0);
    check("areset_exp", 32'(exp_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef PROG_TIMER_PRESCALE_EN
    // prescale=2, L=2 periodic: pulses every 6 cycles, first at start+6.
    start = 1'b1; mode = 1'b1; loadvalue = 26'd2; prescale = 8'd2;
    step();
    start = 1'b0; prescale = 8'd0;
    for (int k = 1; k <= 18; k++) begin
      step();
      check($sformatf("ps_pulse_c%0d", k), {31'd0, pulse}, (k % 6 == 0) ? 32'd1 : 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_prog_timer

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised countdown timer. Loads a period, counts down on enabled ticks, and emits a one-cycle pulse on expiry.
- Supports one-shot and periodic modes, plus explicit start/stop control and status readback.
- Drives game pacing: sequence playback step timing and player-response timeouts in the Simon datapath.

Parameters:
- WIDTH, 26, bit width of the period and the countdown register.
- EXP_W, 8, width of the saturating expiry counter.
- PRESCALE_W, 8, width of the prescale input. Used only when PROG_TIMER_PRESCALE_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  tick qualifier. When low, the countdown freezes; start/stop still act.
- start  in  1  one-cycle strobe: latch loadvalue and mode, then begin counting.
- stop  in  1  one-cycle strobe: abort and return to IDLE.
- mode  in  1  0 = one-shot, 1 = periodic. Sampled only on start.
- loadvalue  in  WIDTH  period in ticks. Sampled only on start.
- pulse  out  1  registered; high for exactly one clk cycle per expiry.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (one-shot expired). Cleared by start, stop or reset.
- count  out  WIDTH  current remaining ticks.
- exp_count  out  EXP_W  expiries since last start; saturates at all-ones.

Behaviour:
- Reset: asynchronous, active-high. Asserting it forces state IDLE and zeroes pulse, busy, done, count, exp_count and the latched period/mode, regardless of clk.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on one-shot expiry.
  - RUN -> RUN on periodic expiry, with reload.
  - Any state -> IDLE on stop.
  - Any state -> RUN on start (restart).
- Simultaneous start and stop: stop wins.
- Start actions:
  - period_q <= (loadvalue == 0) ? 1 : loadvalue.
  - mode_q <= mode.
  - count <= that same value; exp_count <= 0; done <= 0.
  - No pulse is generated on the start cycle.
- Tick: tick = enable (see Optional Feature).
- RUN with tick:
  - If count > 1: count decrements by 1.
  - If count == 1 (expiry): pulse <= 1 next cycle; exp_count increments, saturating.
  - Periodic expiry: count <= period_q.
  - One-shot expiry: count <= 0, state <= DONE, done <= 1.
- RUN without tick: count holds, no pulse.
- Latency: with enable held high, the first pulse is high in cycle start+L, where L is the effective period. Periodic pulses then repeat every L cycles with no gap or slip. L = 1 in periodic mode gives pulse high continuously, one pulse per cycle.
- Mid-run changes to loadvalue or mode have no effect until the next start.
- Restart while in RUN discards the in-flight count. A pending expiry in that same cycle is suppressed: start has priority over expiry.
- Stop in the cycle of an expiry suppresses the pulse.
- pulse is never asserted in IDLE or DONE, except for its single trailing cycle after the expiry that caused the DONE transition.
- count is WIDTH bits unsigned and never wraps below 0.

Optional Feature:
- Macro: PROG_TIMER_PRESCALE_EN.
- Defined:
  - Adds input prescale [PRESCALE_W-1:0].
  - tick asserts once every (prescale+1) enabled clk cycles.
  - The prescaler clears on start, stop and reset, so the first tick occurs (prescale+1) enabled cycles after start.
  - prescale is sampled on start.
  - First pulse lands at start + L*(prescale+1) with enable high.
- Undefined: the port is absent and tick = enable.

Decomposition:
- Shared package simon_timer_pkg contains:
  - state enum timer_state_e {T_IDLE, T_RUN, T_DONE}.
  - mode constants TMODE_ONESHOT = 1'b0 and TMODE_PERIODIC = 1'b1.
  - default width localparams.
- One natural sub-module: tick_prescaler (counter plus clear, emits tick). Instantiated only under PROG_TIMER_PRESCALE_EN.

Test Plan:
- One-shot: mode=0, loadvalue=5, enable=1, start at cycle 10 -> single pulse at cycle 15; done=1 from cycle 15; count=0; exp_count=1; no further pulses over 50 cycles.
- Periodic: mode=1, loadvalue=3, start at cycle 0, run 20 cycles -> pulses at 3, 6, 9, 12, 15, 18; busy stays high; exp_count=6.
- Pause: periodic, loadvalue=4; enable low for cycles 2–5 -> count frozen at 2; first pulse delayed to cycle 8.
- Simultaneous events, as three sub-cases:
  - start+stop same cycle -> IDLE, no pulse.
  - stop in the expiry cycle -> no pulse.
  - restart with loadvalue=7 at the expiry cycle -> no pulse; next pulse 7 cycles later.
- Boundaries and reset:
  - loadvalue=0 one-shot -> pulse 1 cycle after start.
  - Periodic L=1 for 300 cycles -> exp_count saturates at 255.
  - Asynchronous reset mid-run (between clk edges) -> all outputs 0 immediately.
- With PROG_TIMER_PRESCALE_EN: prescale=2, loadvalue=2, periodic -> pulses every 6 cycles, first at start+6.
